pulse_stretch: RTL and testbench

- Pulse-to-level converter: the complement of the level-to-pulse edge generator.
- Takes a single-cycle PULSE_SIG, typically a synchronized strobe arriving in the destination clock domain, and produces LVL_SIG held high for a programmable number of CLK cycles.
- Flags completion with a one-cycle DONE pulse and flags overlapping triggers on OVERLAP.
- Used wherever a strobe must drive enable or busy logic that needs a stable level.

---
 rtl/pulse_stretch.sv | 101 ++++++++++
 tb/tb_pulse_stretch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// Pulse-to-level converter: stretches a trigger strobe into a level held for STRETCH_LEN cycles,
// with a one-cycle DONE after the level falls. Define PULSE_STRETCH_RETRIG_EN for a retriggerable stretch.
module pulse_stretch #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PULSE_SIG,
  input  logic [CNT_WIDTH-1:0] STRETCH_LEN,
  output logic                 LVL_SIG,
  output logic                 DONE,
  output logic                 OVERLAP
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lvl_q, lvl_d;
  logic                 done_q, done_d;
  logic                 overlap_q, overlap_d;

  logic                 len_nz;
  logic [CNT_WIDTH-1:0] len_m1;

  assign len_nz = (STRETCH_LEN != CNT_ZERO);
  assign len_m1 = STRETCH_LEN - CNT_ONE;

  // State, counter and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      lvl_q     <= 1'b0;
      done_q    <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      done_q    <= done_d;
      overlap_q <= overlap_d;
    end
  end

  // Next state and down-counter; the counter never wraps below zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (PULSE_SIG && len_nz) begin
          state_d = S_ACTIVE;
          cnt_d   = len_m1;
        end
      end
      S_ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIG_EN
        if (PULSE_SIG && len_nz) begin
          cnt_d = len_m1;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`else
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the transition, registered so no input reaches an output combinationally.
  always_comb begin
    lvl_d     = 1'b0;
    done_d    = 1'b0;
    overlap_d = 1'b0;
    lvl_d     = (state_d == S_ACTIVE);
    done_d    = (state_q == S_ACTIVE) && (state_d == S_IDLE);
    overlap_d = (state_q == S_ACTIVE) && PULSE_SIG;
  end

  assign LVL_SIG = lvl_q;
  assign DONE    = done_q;
  assign OVERLAP = overlap_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch; expected per-cycle outputs go through a scoreboard queue.
// Expectations follow the build: define PULSE_STRETCH_RETRIG_EN for both bench and DUT together.
module tb_pulse_stretch;

  localparam int unsigned CNT_WIDTH = 8;

  typedef struct {
    logic lvl;
    logic done;
    logic ovl;
    int   cyc;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 pulse_sig;
  logic [CNT_WIDTH-1:0] stretch_len;
  logic                 lvl_sig;
  logic                 done;
  logic                 overlap;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  string tag;

  pulse_stretch #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK         (clk),
    .RST         (rst),
    .PULSE_SIG   (pulse_sig),
    .STRETCH_LEN (stretch_len),
    .LVL_SIG     (lvl_sig),
    .DONE        (done),
    .OVERLAP     (overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_win(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Drive inputs for relative edge t, queue the outputs expected in cycle t+1, then check them.
  task automatic step(input logic p, input int len, input logic r, input int t,
                      input logic e_lvl, input logic e_done, input logic e_ovl);
    exp_t e;
    exp_t got;
    pulse_sig   = p;
    stretch_len = CNT_WIDTH'(len);
    rst         = r;
    e.lvl  = e_lvl;
    e.done = e_done;
    e.ovl  = e_ovl;
    e.cyc  = t + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checks++;
    assert (lvl_sig === got.lvl) else begin
      failures++;
      $error("FAIL %s lvl cyc=%0d got=%b exp=%b", tag, got.cyc, lvl_sig, got.lvl);
    end
    checks++;
    assert (done === got.done) else begin
      failures++;
      $error("FAIL %s done cyc=%0d got=%b exp=%b", tag, got.cyc, done, got.done);
    end
    checks++;
    assert (overlap === got.ovl) else begin
      failures++;
      $error("FAIL %s overlap cyc=%0d got=%b exp=%b", tag, got.cyc, overlap, got.ovl);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, i, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    pulse_sig   = 1'b1;
    stretch_len = CNT_WIDTH'(4);

    tag = "reset";
    for (int t = 0; t < 2; t++) step(1'b1, 4, 1'b1, t, 1'b0, 1'b0, 1'b0);
    tag = "reset_release";
    for (int t = 0; t < 7; t++)
      step(t == 0, 4, 1'b0, t, in_win(t + 1, 1, 4), (t + 1) == 5, 1'b0);
    idle(2);

    tag = "basic5";
    for (int t = 0; t < 8; t++)
      step(t == 0, 5, 1'b0, t, in_win(t + 1, 1, 5), (t + 1) == 6, 1'b0);
    idle(2);

    tag = "zero_len";
    for (int t = 0; t < 5; t++) step(t == 0, 0, 1'b0, t, 1'b0, 1'b0, 1'b0);

    tag = "max_len";
    for (int t = 0; t < 258; t++)
      step(t == 0, 255, 1'b0, t, in_win(t + 1, 1, 255), (t + 1) == 256, 1'b0);
    idle(2);

    tag = "overlap8";
    for (int t = 0; t < 15; t++) begin
`ifdef PULSE_STRETCH_RETRIG_EN
      step(t == 0 || t == 4, 8, 1'b0, t, in_win(t + 1, 1, 12), (t + 1) == 13, (t + 1) == 5);
`else
      step(t == 0 || t == 4, 8, 1'b0, t, in_win(t + 1, 1, 8), (t + 1) == 9, (t + 1) == 5);
`endif
    end
    idle(2);

    tag = "overlap_last_cycle";
    for (int t = 0; t < 9; t++) begin
`ifdef PULSE_STRETCH_RETRIG_EN
      step(t == 0 || t == 3, 3, 1'b0, t, in_win(t + 1, 1, 6), (t + 1) == 7, (t + 1) == 4);
`else
      step(t == 0 || t == 3, 3, 1'b0, t, in_win(t + 1, 1, 3), (t + 1) == 4, (t + 1) == 4);
`endif
    end
    idle(2);

    tag = "retrig_zero_len";
    for (int t = 0; t < 7; t++)
      step(t == 0 || t == 2, (t == 2) ? 0 : 4, 1'b0, t, in_win(t + 1, 1, 4), (t + 1) == 5, (t + 1) == 3);
    idle(2);

    tag = "back_to_back";
    for (int t = 0; t < 10; t++)
      step(t == 0 || t == 4, 3, 1'b0, t, in_win(t + 1, 1, 3) || in_win(t + 1, 5, 7),
           (t + 1) == 4 || (t + 1) == 8, 1'b0);
    idle(2);

    tag = "reset_mid";
    for (int t = 0; t < 10; t++)
      step(t == 0, 6, t == 2, t, in_win(t + 1, 1, 2), 1'b0, 1'b0);
    idle(2);

    tag = "len_change";
    for (int t = 0; t < 7; t++)
      step(t == 0, (t == 0) ? 3 : 9, 1'b0, t, in_win(t + 1, 1, 3), (t + 1) == 4, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
